score_bcd_disp: RTL and testbench

SCORE_BCD_DISP -- requirements
Module: score_bcd_disp

---
 rtl/score_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/score_bcd_disp.sv | 230 +++++++++++++++++++++++
 tb/tb_score_bcd_disp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score display: game-state codes, segment
// patterns and the commit FSM state type.
package score_pkg;

    // Game-state encodings driven by the game logic
    localparam logic [1:0] STATE_START     = 2'b00;
    localparam logic [1:0] STATE_RUN       = 2'b01;
    localparam logic [1:0] STATE_OVER      = 2'b10;
    localparam logic [1:0] STATE_SHOW_HIGH = 2'b11;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low digit patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Commit FSM: IDLE waits for a tick, ADD drains work into the score
    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_ADD  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern. Codes above 9 show '0'.
import score_pkg::*;

module seg7_decode (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup; non-BCD codes fall back to the '0' pattern
    always_comb begin
        o_seg = SEG_TABLE[0];
        case (i_bcd)
            4'd0:    o_seg = SEG_TABLE[0];
            4'd1:    o_seg = SEG_TABLE[1];
            4'd2:    o_seg = SEG_TABLE[2];
            4'd3:    o_seg = SEG_TABLE[3];
            4'd4:    o_seg = SEG_TABLE[4];
            4'd5:    o_seg = SEG_TABLE[5];
            4'd6:    o_seg = SEG_TABLE[6];
            4'd7:    o_seg = SEG_TABLE[7];
            4'd8:    o_seg = SEG_TABLE[8];
            4'd9:    o_seg = SEG_TABLE[9];
            default: o_seg = SEG_TABLE[0];
        endcase
    end

endmodule

// File: rtl/score_bcd_disp.sv
// BCD score keeper with high-score register and registered 7-segment output.
// Scoring events accumulate in pend, move to work on a periodic commit tick,
// and work is drained one BCD increment per cycle while busy is high.
import score_pkg::*;

module score_bcd_disp #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_CYCLES = 30_000_000,
    parameter int WEIGHT_K    = 1,
    parameter int WEIGHT_H    = 4,
    parameter int PEND_W      = 8
) (
    input  logic                    CLK_50M,
    input  logic                    RST,
    input  logic                    score_k,
    input  logic                    score_h,
    input  logic [1:0]              game_state,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    busy
);

    localparam int          BCD_W    = 4 * NUM_DIGITS;
    localparam int          TICK_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [31:0] PEND_MAX = 32'((64'd1 << PEND_W) - 64'd1);

    // Add one to a packed BCD value, rippling the carry upward digit by digit
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] res;
        logic             carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                    carry         = 1'b1;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[4*i +: 4] = v[4*i +: 4];
            end
        end
        return res;
    endfunction

    // True when every digit is 9 (score cannot grow further)
    function automatic logic bcd_all_nine(input logic [BCD_W-1:0] v);
        logic all9;
        all9 = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                all9 = 1'b0;
            end else begin
                all9 = all9;
            end
        end
        return all9;
    endfunction

    // a > b, compared digit by digit from the most significant digit
    function automatic logic bcd_greater(input logic [BCD_W-1:0] a,
                                         input logic [BCD_W-1:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!done && (a[4*i +: 4] > b[4*i +: 4])) begin
                gt   = 1'b1;
                done = 1'b1;
            end else if (!done && (a[4*i +: 4] < b[4*i +: 4])) begin
                done = 1'b1;
            end else begin
                done = done;
            end
        end
        return gt;
    endfunction

    // Clamp a point sum to the pending accumulator range
    function automatic logic [PEND_W-1:0] pend_sat(input logic [31:0] v);
        if (v > PEND_MAX) begin
            return PEND_MAX[PEND_W-1:0];
        end else begin
            return v[PEND_W-1:0];
        end
    endfunction

    logic                    r_k_q;
    logic                    r_h_q;
    logic [1:0]              r_gs;
    logic [TICK_W-1:0]       r_tick_cnt;
    logic [PEND_W-1:0]       r_pend;
    logic [PEND_W-1:0]       r_work;
    logic [BCD_W-1:0]        r_score;
    logic [BCD_W-1:0]        r_high;
    logic [7*NUM_DIGITS-1:0] r_seg;
    fsm_state_t              r_state;
    fsm_state_t              w_state_next;

    logic                    w_run;
    logic                    w_start;
    logic                    w_tick;
    logic                    w_transfer;
    logic [31:0]             w_edge_pts;
    logic [BCD_W-1:0]        w_disp_bcd;
    logic [7*NUM_DIGITS-1:0] w_seg_dec;

    assign w_run      = (game_state == STATE_RUN);
    assign w_start    = (game_state == STATE_START);
    assign w_tick     = w_run && (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));
    assign w_transfer = w_tick && (r_state == FSM_IDLE);
    // Edges only score while the game is running
    assign w_edge_pts = ((w_run && score_k && !r_k_q) ? 32'(WEIGHT_K) : 32'd0)
                      + ((w_run && score_h && !r_h_q) ? 32'(WEIGHT_H) : 32'd0);

    // FSM state register
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_state <= FSM_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: start on a nonzero transfer, stop when work runs out
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = FSM_IDLE;
        end else begin
            case (r_state)
                FSM_IDLE: begin
                    if (w_transfer && (r_pend != {PEND_W{1'b0}})) begin
                        w_state_next = FSM_ADD;
                    end else begin
                        w_state_next = FSM_IDLE;
                    end
                end
                FSM_ADD: begin
                    if (w_run && (r_work == PEND_W'(1))) begin
                        w_state_next = FSM_IDLE;
                    end else begin
                        w_state_next = FSM_ADD;
                    end
                end
                default: w_state_next = FSM_IDLE;
            endcase
        end
    end

    // Edge capture, tick counter, pend/work accumulators, score and high score
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_k_q      <= 1'b0;
            r_h_q      <= 1'b0;
            r_gs       <= STATE_START;
            r_tick_cnt <= {TICK_W{1'b0}};
            r_pend     <= {PEND_W{1'b0}};
            r_work     <= {PEND_W{1'b0}};
            r_score    <= {BCD_W{1'b0}};
            r_high     <= {BCD_W{1'b0}};
        end else begin
            r_k_q <= score_k;
            r_h_q <= score_h;
            r_gs  <= game_state;
            if (w_start) begin
                r_tick_cnt <= {TICK_W{1'b0}};
                r_pend     <= {PEND_W{1'b0}};
                r_work     <= {PEND_W{1'b0}};
                r_score    <= {BCD_W{1'b0}};
            end else if (w_run) begin
                r_tick_cnt <= w_tick ? {TICK_W{1'b0}} : (r_tick_cnt + TICK_W'(1));
                // The tick cycle's own edges go into the freshly emptied pend
                if (w_transfer) begin
                    r_work <= r_pend;
                    r_pend <= pend_sat(w_edge_pts);
                end else begin
                    r_pend <= pend_sat(32'(r_pend) + w_edge_pts);
                end
                // Work drains even when the score is pinned at all nines
                if (r_state == FSM_ADD) begin
                    r_work <= r_work - PEND_W'(1);
                    if (!bcd_all_nine(r_score)) begin
                        r_score <= bcd_inc(r_score);
                    end else begin
                        r_score <= r_score;
                    end
                end else begin
                    r_score <= r_score;
                end
            end else begin
                r_tick_cnt <= r_tick_cnt;
            end
            // Latch a new record on the RUN -> OVER transition only
            if ((r_gs == STATE_RUN) && (game_state == STATE_OVER)
                && bcd_greater(r_score, r_high)) begin
                r_high <= r_score;
            end else begin
                r_high <= r_high;
            end
        end
    end

    assign w_disp_bcd = (game_state == STATE_SHOW_HIGH) ? r_high : r_score;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_decode u_dec (
            .i_bcd (w_disp_bcd[4*g +: 4]),
            .o_seg (w_seg_dec[7*g +: 7])
        );
    end

    // Registered display: blank in START, else decoded score or high score
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            r_seg <= {NUM_DIGITS{SEG_BLANK}};
        end else if (w_start) begin
            r_seg <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            r_seg <= w_seg_dec;
        end
    end

    assign seg  = r_seg;
    assign busy = (r_state == FSM_ADD);

endmodule

// File: tb/tb_score_bcd_disp.sv
// Self-checking bench for score_bcd_disp: a 2-digit and a 4-digit instance,
// both with a 10-cycle commit tick. Expected scores are queued as stimulus is
// driven and popped when the DUT has settled.
module tb_score_bcd_disp;

    logic        clk;
    logic        rst;
    logic        k2, h2, k4, h4;
    logic [1:0]  gs2, gs4;
    logic [13:0] seg2;
    logic [27:0] seg4;
    logic        busy2, busy4;

    int n_tests;
    int n_fail;
    int model2;
    int q2[$];
    int q4[$];

    score_bcd_disp #(.NUM_DIGITS(2), .TICK_CYCLES(10)) dut2 (
        .CLK_50M(clk), .RST(rst), .score_k(k2), .score_h(h2),
        .game_state(gs2), .seg(seg2), .busy(busy2));

    score_bcd_disp #(.NUM_DIGITS(4), .TICK_CYCLES(10)) dut4 (
        .CLK_50M(clk), .RST(rst), .score_k(k4), .score_h(h4),
        .game_state(gs4), .seg(seg4), .busy(busy4));

    always #10 clk = ~clk;

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] exp_seg(input int val, input int nd);
        logic [27:0] r;
        int v;
        r = '1;
        v = val;
        for (int i = 0; i < nd; i++) begin
            r[7*i +: 7] = digit_pat(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic pulses2(input int nk, input int nh);
        for (int i = 0; i < nk; i++) begin
            k2 = 1'b1; @(negedge clk); k2 = 1'b0; @(negedge clk);
        end
        for (int i = 0; i < nh; i++) begin
            h2 = 1'b1; @(negedge clk); h2 = 1'b0; @(negedge clk);
        end
        model2 = model2 + nk + 4 * nh;
        if (model2 > 99) model2 = 99;
        q2.push_back(model2);
    endtask

    task automatic settle(input bit use4, output bit ok);
        int quiet;
        ok = 1'b0;
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((use4 ? busy4 : busy2) == 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 25) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_drain(output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy2) begin ok = 1'b1; break; end
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (!busy2) begin ok = 1'b1; break; end
                cyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_tests++; if (seg2 !== 14'h3FFF) begin n_fail++; $display("FAIL reset_seg2 got %h want 3fff", seg2); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got %b want 0", busy2); end
        n_tests++; if (seg4 !== 28'hFFFFFFF) begin n_fail++; $display("FAIL reset_seg4 got %h want fffffff", seg4); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (seg2 !== 14'h3FFF) begin n_fail++; $display("FAIL start_blank got %h want 3fff", seg2); end
    endtask

    task automatic test_basic;
        int cyc;
        bit ok;
        logic [27:0] e;
        gs2 = 2'b01; k2 = 1'b1;
        @(negedge clk); k2 = 1'b0; h2 = 1'b1;
        @(negedge clk); h2 = 1'b0;
        model2 = 5; q2.push_back(model2);
        wait_drain(cyc, ok);
        n_tests++; if (!ok || cyc != 5) begin n_fail++; $display("FAIL basic_busy_cycles got %0d (ok=%0d) want 5", cyc, ok); end
        @(negedge clk);
        e = exp_seg(q2.pop_front(), 2);
        n_tests++; if (seg2 !== e[13:0]) begin n_fail++; $display("FAIL basic_seg got %h want %h", seg2, e[13:0]); end
        n_tests++; if (seg2[6:0] !== 7'b0010010) begin n_fail++; $display("FAIL basic_digit0 got %b want 0010010", seg2[6:0]); end
        n_tests++; if (seg2[13:7] !== 7'b1000000) begin n_fail++; $display("FAIL basic_digit1 got %b want 1000000", seg2[13:7]); end
    endtask

    task automatic test_simultaneous;
        bit found;
        bit ok;
        int cyc;
        logic [27:0] e;
        k2 = 1'b1; @(negedge clk); k2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (busy2) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL simul_align got busy=%b want 1 within 40 cycles", busy2); end
        // tick counter restarted at the edge just before this negedge
        repeat (2) @(negedge clk);
        k2 = 1'b1; @(negedge clk); k2 = 1'b0;
        repeat (6) @(negedge clk);
        k2 = 1'b1; h2 = 1'b1;
        @(negedge clk); k2 = 1'b0; h2 = 1'b0;
        model2 = 12; q2.push_back(model2);
        n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL simul_prior_busy got %b want 1", busy2); end
        @(negedge clk);
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL simul_prior_done got %b want 0", busy2); end
        wait_drain(cyc, ok);
        n_tests++; if (!ok || cyc != 5) begin n_fail++; $display("FAIL simul_pend5 got %0d (ok=%0d) want 5", cyc, ok); end
        @(negedge clk);
        e = exp_seg(q2.pop_front(), 2);
        n_tests++; if (seg2 !== e[13:0]) begin n_fail++; $display("FAIL simul_seg got %h want %h", seg2, e[13:0]); end
    endtask

    task automatic test_over_frozen;
        bit ok;
        logic [27:0] e;
        gs2 = 2'b10;
        k2 = 1'b1; @(negedge clk); k2 = 1'b0;
        settle(1'b0, ok);
        e = exp_seg(12, 2);
        n_tests++; if (!ok || seg2 !== e[13:0]) begin n_fail++; $display("FAIL over_frozen got %h want %h", seg2, e[13:0]); end
    endtask

    task automatic test_high_score;
        bit ok;
        logic [27:0] e;
        // game 2 ends at 08
        gs2 = 2'b00; @(negedge clk);
        gs2 = 2'b01; model2 = 0;
        pulses2(8, 0);
        settle(1'b0, ok);
        e = exp_seg(q2.pop_front(), 2);
        n_tests++; if (!ok || seg2 !== e[13:0]) begin n_fail++; $display("FAIL game2_score got %h want %h", seg2, e[13:0]); end
        gs2 = 2'b10; @(negedge clk);
        gs2 = 2'b11; repeat (2) @(negedge clk);
        e = exp_seg(12, 2);
        n_tests++; if (seg2 !== e[13:0]) begin n_fail++; $display("FAIL high_kept12 got %h want %h", seg2, e[13:0]); end
        // game 3 ends at 30
        gs2 = 2'b00; @(negedge clk);
        gs2 = 2'b01; model2 = 0;
        pulses2(2, 7);
        settle(1'b0, ok);
        gs2 = 2'b10; @(negedge clk);
        gs2 = 2'b11; repeat (2) @(negedge clk);
        e = exp_seg(q2.pop_front(), 2);
        n_tests++; if (!ok || seg2 !== e[13:0]) begin n_fail++; $display("FAIL high_new30 got %h want %h", seg2, e[13:0]); end
    endtask

    task automatic test_saturate;
        bit ok;
        int cyc;
        logic [27:0] e;
        gs2 = 2'b00; @(negedge clk);
        gs2 = 2'b01; model2 = 0;
        pulses2(1, 24);
        settle(1'b0, ok);
        e = exp_seg(q2.pop_front(), 2);
        n_tests++; if (!ok || seg2 !== e[13:0]) begin n_fail++; $display("FAIL sat_97 got %h want %h", seg2, e[13:0]); end
        pulses2(0, 1);
        wait_drain(cyc, ok);
        n_tests++; if (!ok || cyc != 4) begin n_fail++; $display("FAIL sat_busy_cycles got %0d (ok=%0d) want 4", cyc, ok); end
        @(negedge clk);
        e = exp_seg(q2.pop_front(), 2);
        n_tests++; if (seg2 !== e[13:0]) begin n_fail++; $display("FAIL sat_99 got %h want %h", seg2, e[13:0]); end
    endtask

    task automatic test_four_digits;
        bit ok;
        logic [27:0] e;
        gs4 = 2'b01;
        for (int i = 0; i < 150; i++) begin
            k4 = 1'b1; @(negedge clk); k4 = 1'b0; @(negedge clk);
        end
        q4.push_back(150);
        settle(1'b1, ok);
        e = exp_seg(q4.pop_front(), 4);
        n_tests++; if (!ok || seg4 !== e) begin n_fail++; $display("FAIL four_digit_150 got %h want %h", seg4, e); end
    endtask

    task automatic test_reset_mid_add;
        bit found;
        h2 = 1'b1; @(negedge clk); h2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (busy2) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL midadd_enter got busy=%b want 1", busy2); end
        #3 rst = 1'b1;
        #1;
        n_tests++; if (seg2 !== 14'h3FFF) begin n_fail++; $display("FAIL midadd_seg got %h want 3fff", seg2); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL midadd_busy got %b want 0", busy2); end
        @(negedge clk);
        rst = 1'b0; gs2 = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        k2 = 1'b0; h2 = 1'b0; k4 = 1'b0; h4 = 1'b0;
        gs2 = 2'b00; gs4 = 2'b00;
        n_tests = 0; n_fail = 0; model2 = 0;
        test_reset();
        test_basic();
        test_simultaneous();
        test_over_frozen();
        test_high_score();
        test_saturate();
        test_four_digits();
        test_reset_mid_add();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
